int_square_unit: RTL and testbench
==================================

// Module: int_square_unit
// PURPOSE
//  Iterative integer squarer: the inverse of the integer sqrt datapath. It accepts an
//  unsigned SIZE-bit operand and produces the exact 2*SIZE-bit square, retiring
//  STEPS multiplier bits per cycle.
//  It stops early once the remaining multiplier bits are zero.
//  Used to build sqrt test references and to check sqrt results (res^2 <= num < (res+1)^2).
// PARAMETERS
//  SIZE   32  operand width in bits; the result is 2*SIZE bits wide
//  STEPS  2   multiplier bits retired per RUN cycle; must divide SIZE
// PORTS
//  clk       in   1         rising-edge clock
//  rst       in   1         synchronous, active-high reset
//  start     in   1         request to square num0; accepted only while ready=1
//  num0      in   SIZE      unsigned operand, sampled on the accepting edge
//  ready     out  1         high in IDLE; the unit can accept start
//  busy      out  1         high in RUN and in DONE
//  finished  out  1         one-cycle pulse; res is valid in that cycle
//  res       out  2*SIZE    square of the last accepted operand; held until the next accept
// BEHAVIOUR
//  Registers
//   - acc: 2*SIZE bits; drives res.
//   - mcand: 2*SIZE bits; operand shifted left.
//   - mplier: SIZE bits; operand shifted right.
//   - state: IDLE, RUN or DONE.
//  Reset
//   - state=IDLE; acc, mcand and mplier = 0.
//   - ready=1, busy=0, finished=0, res=0.
//  IDLE
//   - On start=1, the next edge loads mcand={SIZE'b0,num0} and mplier=num0, clears acc,
//     and moves to RUN.
//   - start=0: stay in IDLE; res holds its value.
//  RUN, each edge
//   - acc += sum over j in [0,STEPS) of (mplier[j] ? mcand<<j : 0).
//   - mcand <<= STEPS; mplier >>= STEPS (logical).
//   - If the shifted mplier is 0, go to DONE. Otherwise stay in RUN.
//  DONE
//   - finished=1 for exactly one cycle, with res=final acc.
//   - Next edge: go to IDLE unconditionally.
//  Latency
//   - Let p be the index of the top set bit of num0. n = floor(p/STEPS)+1 RUN cycles.
//   - num0=0 gives n=1 (one RUN cycle that adds 0).
//   - finished is high in cycle n+1 after the accepting edge.
//   - Worst case: n = SIZE/STEPS (16 at the defaults).
//  Width
//   - All adds are 2*SIZE bits wide. No overflow is possible: (2^SIZE-1)^2 < 2^(2*SIZE).
//   - No truncation or saturation is applied.
//  Boundaries
//   - start in RUN or DONE: ignored. It is not queued, and num0 is not sampled.
//   - start on the same edge the unit leaves DONE: ignored. It is accepted in the next
//     IDLE cycle if still high.
//   - rst in any state, including mid-RUN: return to the reset state on that edge.
//     finished stays 0 and the partial result is discarded.
//   - rst and start on the same edge: rst wins.
//   - num0 changing while busy: no effect.
// STRUCTURE
//  - Shared header (fpu_int_defs.vh): the state encodings
//    (SQ_IDLE=2'd0, SQ_RUN=2'd1, SQ_DONE=2'd2).
//    SIZE and STEPS defaults are shared with the sqrt datapath.
//  - Sub-module square_step: combinational. Inputs prev_acc, prev_mcand, prev_mplier.
//    Outputs cur_acc, cur_mcand, cur_mplier.
//    It retires one multiplier bit. STEPS instances are chained in RUN, mirroring the
//    sqrt_unit level chain.
//  - Control FSM and the registers live in int_square_unit. Use the existing register
//    and multiplexer blocks for acc, mcand and mplier, with a load/clear select.
// TESTING
//  1. num0=0, start for 1 cycle -> finished in cycle 2 after the accept edge; res=0.
//  2. num0=3 -> n=1; finished in cycle 2; res=9.
//  3. num0=65536 (p=16) -> n=9; finished in cycle 10; res=64'h0000_0001_0000_0000.
//  4. num0=32'hFFFF_FFFF -> n=16; finished in cycle 17; res=64'hFFFF_FFFE_0000_0001.
//  5. num0=1000, then start=1 with num0=7 held during RUN and DONE
//     -> the first finished gives res=1000000. The start held through DONE is accepted
//     in the following IDLE cycle and yields 49. ready=0 throughout busy.
//  6. num0=32'hFFFF_FFFF, rst=1 on the 5th RUN edge -> next cycle ready=1, res=0, and no
//     finished pulse. A following start with 12 -> res=144.

Source files
------------

// File: rtl/int_square_unit_pkg.sv
// Shared definitions for the iterative integer squarer: default widths and the
// control state encoding (kept identical to the sqrt datapath encodings).
package int_square_unit_pkg;

    localparam int SQ_SIZE  = 32;
    localparam int SQ_STEPS = 2;

    typedef enum logic [1:0] {
        SQ_IDLE = 2'd0,
        SQ_RUN  = 2'd1,
        SQ_DONE = 2'd2
    } sq_state_e;

    // Datapath register select: hold, load a new operand, or retire STEPS bits.
    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_STEP = 2'd2
    } sq_sel_e;

endpackage

// File: rtl/int_square_unit_square_step.sv
// One shift-and-add stage: retires the lowest multiplier bit into the accumulator.
module square_step #(
    parameter int SIZE = 32
) (
    input  logic [2*SIZE-1:0] prev_acc,
    input  logic [2*SIZE-1:0] prev_mcand,
    input  logic [SIZE-1:0]   prev_mplier,
    output logic [2*SIZE-1:0] cur_acc,
    output logic [2*SIZE-1:0] cur_mcand,
    output logic [SIZE-1:0]   cur_mplier
);

    assign cur_acc    = prev_acc + (prev_mplier[0] ? prev_mcand : '0);
    assign cur_mcand  = prev_mcand << 1;
    assign cur_mplier = prev_mplier >> 1;

endmodule

// File: rtl/int_square_unit.sv
// Iterative squarer: shift-and-add of the operand by itself, STEPS bits per cycle,
// stopping as soon as the remaining multiplier bits are all zero.
module int_square_unit
    import int_square_unit_pkg::*;
#(
    parameter int SIZE  = SQ_SIZE,
    parameter int STEPS = SQ_STEPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   num0,
    output logic              ready,
    output logic              busy,
    output logic              finished,
    output logic [2*SIZE-1:0] res,
    output sq_state_e         dbg_state
);

    sq_state_e         state_q;
    logic              ready_q, busy_q, finished_q;
    logic [2*SIZE-1:0] acc_q, acc_d;
    logic [2*SIZE-1:0] mcand_q, mcand_d;
    logic [SIZE-1:0]   mplier_q, mplier_d;
    sq_sel_e           sel;

    logic [2*SIZE-1:0] acc_c    [STEPS+1];
    logic [2*SIZE-1:0] mcand_c  [STEPS+1];
    logic [SIZE-1:0]   mplier_c [STEPS+1];

    assign acc_c[0]    = acc_q;
    assign mcand_c[0]  = mcand_q;
    assign mplier_c[0] = mplier_q;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        square_step #(.SIZE(SIZE)) u_step (
            .prev_acc    (acc_c[g]),
            .prev_mcand  (mcand_c[g]),
            .prev_mplier (mplier_c[g]),
            .cur_acc     (acc_c[g+1]),
            .cur_mcand   (mcand_c[g+1]),
            .cur_mplier  (mplier_c[g+1])
        );
    end

    always_comb begin
        sel = SEL_HOLD;
        if (state_q == SQ_IDLE && start) sel = SEL_LOAD;
        else if (state_q == SQ_RUN)      sel = SEL_STEP;
    end

    // Load/clear/step multiplexers in front of the datapath registers.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (sel)
            SEL_LOAD: begin
                acc_d    = '0;
                mcand_d  = {{SIZE{1'b0}}, num0};
                mplier_d = num0;
            end
            SEL_STEP: begin
                acc_d    = acc_c[STEPS];
                mcand_d  = mcand_c[STEPS];
                mplier_d = mplier_c[STEPS];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SQ_IDLE;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            case (state_q)
                SQ_IDLE: begin
                    if (start) begin
                        state_q <= SQ_RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SQ_RUN: begin
                    if (mplier_c[STEPS] == '0) begin
                        state_q    <= SQ_DONE;
                        finished_q <= 1'b1;
                    end
                end
                SQ_DONE: begin
                    // start is deliberately not looked at here; it is taken in IDLE.
                    state_q    <= SQ_IDLE;
                    finished_q <= 1'b0;
                    busy_q     <= 1'b0;
                    ready_q    <= 1'b1;
                end
                default: begin
                    state_q    <= SQ_IDLE;
                    finished_q <= 1'b0;
                    busy_q     <= 1'b0;
                    ready_q    <= 1'b1;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign finished  = finished_q;
    assign res       = acc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_int_square_unit.sv
// Directed bench for int_square_unit: vector table for results/latency plus
// hand-written sequences for held start, mid-run reset and reset-vs-start.
module tb_int_square_unit;
    import int_square_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] num0;
    logic        ready, busy, finished;
    logic [63:0] res;
    sq_state_e   dbg_state;

    int checks = 0;
    int failures = 0;

    int_square_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num0      (num0),
        .ready     (ready),
        .busy      (busy),
        .finished  (finished),
        .res       (res),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [63:0] sq;
        int          n;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Accept one operand, scramble num0 while busy, wait for finished.
    task automatic run_one(input logic [31:0] a, input logic [63:0] sq, input int n);
        int  cnt;
        logic bad;
        bad   = 1'b0;
        num0  = a;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt   = 1;
        while (finished !== 1'b1 && cnt < 60) begin
            if (ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            num0 = $urandom;
            tick();
            cnt++;
        end
        chk($sformatf("latency(%0h)", a), 64'(cnt), 64'(n + 1));
        chk($sformatf("res(%0h)", a), res, sq);
        chk($sformatf("flags_busy(%0h)", a), {63'd0, bad}, 64'd0);
        tick();
        chk($sformatf("finished_pulse(%0h)", a), {63'd0, finished}, 64'd0);
        chk($sformatf("ready_after(%0h)", a), {63'd0, ready}, 64'd1);
    endtask

    initial begin
        int cnt;
        logic seen;
        rst   = 1'b1;
        start = 1'b0;
        num0  = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("reset_ready", {63'd0, ready}, 64'd1);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_finished", {63'd0, finished}, 64'd0);
        chk("reset_res", res, 64'd0);
        chk("reset_state", 64'(dbg_state), 64'(SQ_IDLE));

        vecs.push_back('{32'd0,          64'd0,                    1});
        vecs.push_back('{32'd3,          64'd9,                    1});
        vecs.push_back('{32'd65536,      64'h0000_0001_0000_0000,  9});
        vecs.push_back('{32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 16});
        vecs.push_back('{32'd1000,       64'd1000000,              5});
        vecs.push_back('{32'd7,          64'd49,                   2});
        vecs.push_back('{32'd1,          64'd1,                    1});
        vecs.push_back('{32'd4,          64'd16,                   2});
        vecs.push_back('{32'h8000_0000,  64'h4000_0000_0000_0000, 16});
        vecs.push_back('{32'h0000_ABCD,  64'd1934328361,           8});
        vecs.push_back('{32'h0000_FFFF,  64'd4294836225,           8});

        foreach (vecs[i]) run_one(vecs[i].a, vecs[i].sq, vecs[i].n);

        // start held high through RUN and DONE with a new operand
        num0  = 32'd1000;
        start = 1'b1;
        tick();
        num0 = 32'd7;
        cnt  = 1;
        seen = 1'b0;
        while (finished !== 1'b1 && cnt < 60) begin
            if (ready !== 1'b0) seen = 1'b1;
            tick();
            cnt++;
        end
        chk("held_latency", 64'(cnt), 64'd6);
        chk("held_res1", res, 64'd1000000);
        chk("held_ready_low", {63'd0, seen}, 64'd0);
        chk("held_done_ready", {63'd0, ready}, 64'd0);
        tick();
        chk("held_idle_ready", {63'd0, ready}, 64'd1);
        chk("held_idle_res", res, 64'd1000000);
        tick();
        start = 1'b0;
        chk("held_accept_busy", {63'd0, busy}, 64'd1);
        cnt = 1;
        while (finished !== 1'b1 && cnt < 60) begin
            tick();
            cnt++;
        end
        chk("held_latency2", 64'(cnt), 64'd3);
        chk("held_res2", res, 64'd49);
        tick();

        // reset on the 5th RUN edge of a worst-case operand
        num0  = 32'hFFFF_FFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("midrun_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun_ready", {63'd0, ready}, 64'd1);
        chk("midrun_busy_after", {63'd0, busy}, 64'd0);
        chk("midrun_res", res, 64'd0);
        seen = finished;
        repeat (20) begin
            tick();
            seen = seen | finished;
        end
        chk("midrun_no_finish", {63'd0, seen}, 64'd0);
        run_one(32'd12, 64'd144, 2);

        // rst and start on the same edge: rst wins
        num0  = 32'd5;
        start = 1'b1;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_ready", {63'd0, ready}, 64'd1);
        chk("rst_start_state", 64'(dbg_state), 64'(SQ_IDLE));
        chk("rst_start_res", res, 64'd0);
        run_one(32'd5, 64'd25, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
